psum_delay_bank: RTL and testbench
==================================

# psum_delay_bank

Multi-channel, runtime-programmable delay line for signed partial sums, with per-sample valid tagging, pipeline stall and configuration flush. It sits in the conv datapath wherever partial sums must be aligned to a later PE row or accumulator stage. It generalises the fixed single-channel delay: the delay depth is set at run time up to a parametric maximum, and all channels share one enable, one valid and one tap select.

## Interface
- CH_NB, 4: number of parallel psum channels
- SUM_BW, 16: signed width of each psum
- MAX_DELAY, 32: maximum delay in cycles, ≥ 1; sets the number of physical stages
- DEFAULT_DELAY, 27: delay loaded at reset, 1..MAX_DELAY
- DLY_BW, $clog2(MAX_DELAY+1): width of the delay config fields (derived)

- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- i_en  in  1  advance enable; 0 = stall, all stages hold
- i_valid  in  1  input sample valid
- i_psum  in  CH_NB*SUM_BW  channel c at bits [c*SUM_BW +: SUM_BW], signed
- i_cfg_we  in  1  load i_cfg_delay and flush the pipe
- i_cfg_delay  in  DLY_BW  requested delay
- o_valid  out  1  valid tag at the selected tap
- o_psum  out  CH_NB*SUM_BW  data at the selected tap, same packing as i_psum
- o_delay  out  DLY_BW  active delay
- o_empty  out  1  1 when no stage holds a valid tag

## Operation
- Storage: MAX_DELAY stages × CH_NB channels of SUM_BW data, plus a 1-bit valid per stage (shared across channels).
- Advance when i_en=1 and i_cfg_we=0:
  - stage[0] data is loaded with i_valid ? i_psum : 0, per channel.
  - stage[0] valid is loaded with i_valid.
  - stage[k] is loaded from stage[k-1] for k ≥ 1.
- Stall when i_en=0 and i_cfg_we=0: all stages and the valid bits hold. Input is ignored, whatever the state of i_valid.
- Tap: o_psum = data stage[o_delay-1] and o_valid = valid stage[o_delay-1], driven combinationally from registers with no logic after the mux. Stages past the tap still shift but are not observed.
- Config (i_cfg_we=1): the delay register is loaded with clamp(i_cfg_delay): 0 becomes 1 and values above MAX_DELAY become MAX_DELAY. On the same edge every data stage is cleared to 0 and every valid bit to 0.
  - i_cfg_we has priority over i_en. The input sample in that cycle is discarded.
- o_empty = NOR of all MAX_DELAY valid bits, including stages beyond the tap.
- No arithmetic is performed. Data passes bit-exact and sign is preserved.
- Reset: all stages cleared to 0, valid bits cleared to 0, o_delay = DEFAULT_DELAY. After reset: o_valid=0, o_psum=0, o_empty=1.

## Timing
- Latency with i_en held at 1: a sample accepted at edge t appears on the outputs during the cycle after edge t+D-1, i.e. D cycles after it was presented (D = o_delay). D=1 behaves as a single register.
- Stall cycles add one cycle of latency each. A stalled tap keeps presenting the same value and valid.
- A new delay is visible on o_delay the cycle after the i_cfg_we edge. The first valid output is then D' advancing cycles after the first sample accepted after the flush.
- Reset takes priority over cfg and enable on the same edge.
- Asserting reset mid-stream drops all in-flight samples. Nothing is emitted afterwards except samples accepted after reset.

## Test plan
- Reset, then default D=27: drive ramp 1,2,3… with i_valid=1 and i_en=1. Required: o_valid first rises on cycle 27 with o_psum=1 on every channel, ramp continues unbroken, and o_empty=0 from cycle 1.
- Stall: D=4, send 5 samples, hold i_en=0 for 3 cycles mid-stream. Required: outputs frozen for exactly 3 cycles, no sample lost or duplicated, total latency 7 for affected samples.
- Reconfig and clamp:
  - write i_cfg_delay=0: o_delay=1 and the pipe is flushed (o_valid=0, o_empty=1).
  - write 40 with MAX_DELAY=32: o_delay=32.
  - write 5 while a sample is presented: that sample is never output, and the next one appears 5 cycles later.
- Sign and packing: channels carry -32768, 32767, -1, 0 at D=2. Required: exact values on the matching channel slices after 2 cycles.
- Bubbles: alternate i_valid 1/0 at D=3. Required: o_valid pattern is identical to the input shifted by 3, and bubble slots show o_psum=0.
- Reset mid-stream: assert rst while 10 samples are in flight. Required: the next cycle shows o_valid=0, o_psum=0, o_empty=1 and o_delay=27.

Source files
------------

// File: rtl/psum_delay_bank.sv
// Multi-channel programmable delay line for signed partial sums.
// Shared enable/valid/tap select; config write clamps the delay and flushes the pipe.
module psum_delay_bank #(
   parameter int unsigned CH_NB         = 4,
   parameter int unsigned SUM_BW        = 16,
   parameter int unsigned MAX_DELAY     = 32,
   parameter int unsigned DEFAULT_DELAY = 27,
   parameter int unsigned DLY_BW        = $clog2(MAX_DELAY + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_en,
   input  logic                      i_valid,
   input  logic [CH_NB*SUM_BW-1:0]   i_psum,
   input  logic                      i_cfg_we,
   input  logic [DLY_BW-1:0]         i_cfg_delay,
   output logic                      o_valid,
   output logic [CH_NB*SUM_BW-1:0]   o_psum,
   output logic [DLY_BW-1:0]         o_delay,
   output logic                      o_empty
);

   localparam int unsigned PSUM_W = CH_NB * SUM_BW;
   localparam int unsigned IDX_W  = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

   logic [MAX_DELAY-1:0][PSUM_W-1:0] data_q, data_d;
   logic [MAX_DELAY-1:0]             valid_q, valid_d;
   logic [DLY_BW-1:0]                delay_q, delay_d;
   logic [DLY_BW-1:0]                cfg_delay_c;
   logic [IDX_W-1:0]                 tap_idx_c;

   // Requested delay clamped into 1..MAX_DELAY
   always_comb begin
      cfg_delay_c = i_cfg_delay;
      if (i_cfg_delay == '0) begin
         cfg_delay_c = DLY_BW'(1);
      end else if (i_cfg_delay > DLY_BW'(MAX_DELAY)) begin
         cfg_delay_c = DLY_BW'(MAX_DELAY);
      end
   end

   // Next state: flush on config, shift on enable, otherwise hold
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      delay_d = delay_q;
      if (i_cfg_we) begin
         data_d  = '0;
         valid_d = '0;
         delay_d = cfg_delay_c;
      end else if (i_en) begin
         data_d     = data_q << PSUM_W;
         valid_d    = valid_q << 1;
         data_d[0]  = i_valid ? i_psum : PSUM_W'(0);
         valid_d[0] = i_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= '0;
         delay_q <= DLY_BW'(DEFAULT_DELAY);
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         delay_q <= delay_d;
      end
   end

   // Tap mux straight off the stage registers; delay_q is never 0
   assign tap_idx_c = IDX_W'(delay_q - DLY_BW'(1));
   assign o_psum    = data_q[tap_idx_c];
   assign o_valid   = valid_q[tap_idx_c];
   assign o_delay   = delay_q;
   assign o_empty   = ~|valid_q;

endmodule

// File: tb/tb_psum_delay_bank.sv
// Randomized bench for psum_delay_bank against a queue-based history model.
module tb_psum_delay_bank;

   localparam int unsigned CH_NB         = 4;
   localparam int unsigned SUM_BW        = 16;
   localparam int unsigned MAX_DELAY     = 32;
   localparam int unsigned DEFAULT_DELAY = 27;
   localparam int unsigned DLY_BW        = $clog2(MAX_DELAY + 1);
   localparam int unsigned PW            = CH_NB * SUM_BW;
   localparam int unsigned VW            = PW + DLY_BW + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_en;
   logic              i_valid;
   logic [PW-1:0]     i_psum;
   logic              i_cfg_we;
   logic [DLY_BW-1:0] i_cfg_delay;
   logic              o_valid;
   logic [PW-1:0]     o_psum;
   logic [DLY_BW-1:0] o_delay;
   logic              o_empty;

   always #5 clk = ~clk;

   psum_delay_bank #(
      .CH_NB(CH_NB), .SUM_BW(SUM_BW), .MAX_DELAY(MAX_DELAY), .DEFAULT_DELAY(DEFAULT_DELAY)
   ) dut (
      .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .i_psum(i_psum),
      .i_cfg_we(i_cfg_we), .i_cfg_delay(i_cfg_delay), .o_valid(o_valid),
      .o_psum(o_psum), .o_delay(o_delay), .o_empty(o_empty)
   );

   typedef struct packed {
      logic          v;
      logic [PW-1:0] d;
   } ent_t;

   // hist[0] is the most recently accepted sample; hist[D-1] is what the tap shows
   ent_t        hist[$];
   int unsigned m_delay;
   int          total = 0;
   int          bad   = 0;

   task automatic model_clear();
      hist.delete();
      for (int i = 0; i < int'(MAX_DELAY); i++) hist.push_back('0);
   endtask

   function automatic logic [VW-1:0] exp_vec();
      ent_t tap;
      logic empty;
      tap   = hist[m_delay-1];
      empty = 1'b1;
      foreach (hist[i]) if (hist[i].v) empty = 1'b0;
      return {tap.v, empty, DLY_BW'(m_delay), tap.d};
   endfunction

   function automatic logic [VW-1:0] act_vec();
      return {o_valid, o_empty, o_delay, o_psum};
   endfunction

   // One clock edge; the model follows the inputs that were present at that edge
   task automatic step();
      ent_t e;
      int unsigned req;
      @(posedge clk);
      if (rst) begin
         model_clear();
         m_delay = DEFAULT_DELAY;
      end else if (i_cfg_we) begin
         model_clear();
         req     = int'(i_cfg_delay);
         m_delay = (req == 0) ? 1 : ((req > MAX_DELAY) ? MAX_DELAY : req);
      end else if (i_en) begin
         e.v = i_valid;
         e.d = i_valid ? i_psum : PW'(0);
         hist.push_front(e);
         void'(hist.pop_back());
      end
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; i_en = 1'b1; i_valid = 1'b0; i_psum = '0;
      i_cfg_we = 1'b0; i_cfg_delay = '0;
   endtask

   function automatic logic [PW-1:0] rnd_psum();
      return {$urandom, $urandom};
   endfunction

   task automatic cfg_delay(input int unsigned d);
      idle_inputs();
      i_cfg_we = 1'b1; i_cfg_delay = DLY_BW'(d);
      step();
      i_cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      i_valid = 1'b1; i_psum = rnd_psum();
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (act_vec() !== {1'b0, 1'b1, DLY_BW'(DEFAULT_DELAY), PW'(0)}) begin
         bad++;
         $display("FAIL reset got=%h exp=%h", act_vec(), {1'b0, 1'b1, DLY_BW'(DEFAULT_DELAY), PW'(0)});
      end
   endtask

   task automatic test_ramp();
      idle_inputs();
      for (int n = 1; n <= 40; n++) begin
         i_valid = 1'b1; i_en = 1'b1; i_psum = {CH_NB{SUM_BW'(n)}};
         step();
         total++;
         if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL ramp cyc=%0d got=%h exp=%h", n, act_vec(), exp_vec());
         end
         if (n == 26 || n == 27) begin
            total++;
            if (o_valid !== (n == 27) || (n == 27 && o_psum !== {CH_NB{SUM_BW'(1)}}) || o_empty !== 1'b0) begin
               bad++;
               $display("FAIL ramp_first cyc=%0d got_v=%b got_d=%h", n, o_valid, o_psum);
            end
         end
      end
   endtask

   task automatic test_stall();
      int vcnt;
      cfg_delay(4);
      vcnt = 0;
      for (int c = 1; c <= 20; c++) begin
         i_en    = !(c >= 6 && c <= 8);
         i_valid = (c <= 5) || (c >= 6 && c <= 8);
         i_psum  = rnd_psum();
         step();
         if (o_valid) vcnt++;
         total++;
         if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL stall cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
         end
      end
      total++;
      if (vcnt != 8) begin
         bad++;
         $display("FAIL stall_count got=%0d exp=8", vcnt);
      end
   endtask

   task automatic test_clamp();
      logic [PW-1:0] a, b;
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         i_valid = 1'b1; i_psum = rnd_psum();
         step();
      end
      cfg_delay(0);
      total++;
      if (o_delay !== DLY_BW'(1) || o_valid !== 1'b0 || o_empty !== 1'b1) begin
         bad++;
         $display("FAIL clamp_zero got d=%0d v=%b e=%b exp d=1 v=0 e=1", o_delay, o_valid, o_empty);
      end
      cfg_delay(40);
      total++;
      if (o_delay !== DLY_BW'(32)) begin
         bad++;
         $display("FAIL clamp_max got=%0d exp=32", o_delay);
      end
      a = rnd_psum();
      b = ~a;
      i_cfg_we = 1'b1; i_cfg_delay = DLY_BW'(5); i_valid = 1'b1; i_psum = a;
      step();
      i_cfg_we = 1'b0; i_psum = b;
      for (int k = 1; k <= 8; k++) begin
         step();
         i_valid = 1'b0; i_psum = a;
         total++;
         if (act_vec() !== exp_vec() || o_valid !== (k == 5) || (k == 5 && o_psum !== b)) begin
            bad++;
            $display("FAIL cfg5 k=%0d got=%h exp=%h", k, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_sign();
      logic [PW-1:0] v;
      v = {16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
      cfg_delay(2);
      i_valid = 1'b1; i_psum = v;
      step();
      i_valid = 1'b0; i_psum = rnd_psum();
      step();
      total++;
      if (o_valid !== 1'b1 || $signed(o_psum[0 +: 16]) !== -16'sd32768 || $signed(o_psum[16 +: 16]) !== 16'sd32767
          || $signed(o_psum[32 +: 16]) !== -16'sd1 || o_psum[48 +: 16] !== 16'h0000) begin
         bad++;
         $display("FAIL sign got v=%b d=%h exp v=1 d=%h", o_valid, o_psum, v);
      end
      total++;
      if (act_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL sign_model got=%h exp=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_bubbles();
      cfg_delay(3);
      for (int c = 0; c < 20; c++) begin
         i_valid = (c % 2 == 0) && (c < 14);
         i_psum  = rnd_psum();
         step();
         total++;
         if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL bubble cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      idle_inputs();
      for (int c = 0; c < 500; c++) begin
         i_en        = ($urandom_range(3, 0) != 0);
         i_valid     = $urandom_range(1, 0) != 0;
         i_psum      = rnd_psum();
         i_cfg_we    = ($urandom_range(40, 0) == 0);
         i_cfg_delay = DLY_BW'($urandom_range(63, 0));
         rst         = ($urandom_range(150, 0) == 0);
         step();
         total++;
         if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL random cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
         end
      end
      idle_inputs();
   endtask

   task automatic test_mid_reset();
      cfg_delay(15);
      for (int c = 0; c < 10; c++) begin
         i_valid = 1'b1; i_psum = rnd_psum();
         step();
      end
      rst = 1'b1; i_cfg_we = 1'b1; i_cfg_delay = DLY_BW'(3);
      step();
      rst = 1'b0; i_cfg_we = 1'b0;
      total++;
      if (act_vec() !== {1'b0, 1'b1, DLY_BW'(DEFAULT_DELAY), PW'(0)}) begin
         bad++;
         $display("FAIL mid_reset got=%h exp=%h", act_vec(), {1'b0, 1'b1, DLY_BW'(DEFAULT_DELAY), PW'(0)});
      end
      for (int c = 0; c < 35; c++) begin
         i_valid = (c < 4); i_psum = rnd_psum();
         step();
         total++;
         if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL post_reset cyc=%0d got=%h exp=%h", c, act_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      model_clear();
      m_delay = DEFAULT_DELAY;
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_ramp();
      test_stall();
      test_clamp();
      test_sign();
      test_bubbles();
      test_random();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
